// File: rtl/jstk_spi_responder.sv
// -----------------------------------------------------------------------------
// jstk_spi_responder
//
// SPI mode-0 slave that imitates a PmodJSTK joystick. On each frame it returns
// five bytes: X[7:0], {6'b0,X[9:8]}, Y[7:0], {6'b0,Y[9:8]}, {5'b0,buttons}.
// The first byte the master sends is an LED command. Its two low bits are
// latched onto `leds` only when bits [7:2] equal CMD_PREFIX.
//
// SS, SCLK and MOSI are oversampled in the clk domain. MISO comes straight from
// a register.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   x_pos       joystick X value, 0..1023
//   y_pos       joystick Y value, 0..1023
//   buttons     {btn2, btn1, trigger}
//   SS          slave select, active low
//   SCLK        SPI clock, CPOL=0 / CPHA=0
//   MOSI        master data out
//   MISO        slave data out; 0 whenever no frame is being shifted
//   leds        last accepted LED command bits {LD2, LD1}
//   busy        high from frame start until SS is released
//   frame_done  one-cycle pulse after the 40th SCLK rising edge of a frame
// -----------------------------------------------------------------------------
module jstk_spi_responder #(
   parameter logic [5:0] CMD_PREFIX  = 6'b100000,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic [2:0] buttons,
   input  logic       SS,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   output logic [1:0] leds,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers plus one delay stage for edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   ss_dly_q;
   logic                   sclk_dly_q;

   // The chains reset to 0, so SS held low across a reset is never seen as a
   // new frame start. The master must release SS before the next frame begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync_q   <= '0;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_dly_q    <= 1'b0;
         sclk_dly_q  <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
         sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   logic ss_s, sclk_s, mosi_s;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;

   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_fall   =  ss_dly_q   & ~ss_s;
   assign ss_rise   = ~ss_dly_q   &  ss_s;
   assign sclk_rise = ~sclk_dly_q &  sclk_s;
   assign sclk_fall =  sclk_dly_q & ~sclk_s;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [39:0] frame_q, frame_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [1:0]  leds_q, leds_d;
   logic        done_q, done_d;
   logic        miso_q, miso_d;

   // A byte completes on the 8th rising edge, which is when the counter is
   // about to wrap from 7 to 0.
   logic byte_end;
   assign byte_end = sclk_rise && (bit_cnt_q == 3'd7);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state. SS release beats any SCLK edge in the same cycle.
   always_comb begin
      state_d = state_q;
      if (ss_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (byte_end && (byte_idx_q == 3'd4)) state_d = ST_DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   // FSM outputs. MISO follows tx bit 7 only while shifting, one cycle behind.
   always_comb begin
      miso_d = (state_q == ST_SHIFT) ? tx_q[7] : 1'b0;
      busy   = (state_q != ST_IDLE);
   end

   // Byte that follows the current one in the snapshot. Indices past the last
   // byte never occur because the FSM leaves SHIFT after byte 4.
   logic [2:0] byte_idx_inc;
   logic [7:0] next_byte;
   assign byte_idx_inc = byte_idx_q + 3'd1;

   always_comb begin
      next_byte = 8'h00;
      case (byte_idx_inc)
         3'd0:    next_byte = frame_q[7:0];
         3'd1:    next_byte = frame_q[15:8];
         3'd2:    next_byte = frame_q[23:16];
         3'd3:    next_byte = frame_q[31:24];
         3'd4:    next_byte = frame_q[39:32];
         default: next_byte = 8'h00;
      endcase
   end

   // Datapath next state
   always_comb begin
      frame_d    = frame_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_cnt_d  = bit_cnt_q;
      byte_idx_d = byte_idx_q;
      leds_d     = leds_q;
      done_d     = 1'b0;
      if (ss_rise) begin
         // A partial byte is dropped. The LED state is kept.
         rx_d       = 8'h00;
         bit_cnt_d  = 3'd0;
         byte_idx_d = 3'd0;
      end else if ((state_q == ST_IDLE) && ss_fall) begin
         frame_d    = {5'b0, buttons,
                       6'b0, y_pos[9:8], y_pos[7:0],
                       6'b0, x_pos[9:8], x_pos[7:0]};
         tx_d       = x_pos[7:0];
         rx_d       = 8'h00;
         bit_cnt_d  = 3'd0;
         byte_idx_d = 3'd0;
      end else if (state_q == ST_SHIFT) begin
         if (sclk_rise) begin
            rx_d      = {rx_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_end && (byte_idx_q == 3'd0) && (rx_d[7:2] == CMD_PREFIX)) begin
               leds_d = rx_d[1:0];
            end
            if (byte_end && (byte_idx_q == 3'd4)) begin
               done_d = 1'b1;
            end
         end else if (sclk_fall) begin
            if (bit_cnt_q != 3'd0) begin
               tx_d = {tx_q[6:0], 1'b0};
            end else begin
               byte_idx_d = byte_idx_inc;
               tx_d       = next_byte;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q    <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         bit_cnt_q  <= '0;
         byte_idx_q <= '0;
         leds_q     <= 2'b00;
         done_q     <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         frame_q    <= frame_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_idx_q <= byte_idx_d;
         leds_q     <= leds_d;
         done_q     <= done_d;
         miso_q     <= miso_d;
      end
   end

   assign MISO       = miso_q;
   assign leds       = leds_q;
   assign frame_done = done_q;

endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI slave that emulates the PmodJSTK joystick module, answering the `PmodJSTK` master interface with the same 5-byte frame format. It sits on a second board or in the system bench, driving `MISO` from locally supplied X/Y/button values. It also decodes the LED command byte the master sends. Everything runs in the `clk` domain: `SS`, `SCLK` and `MOSI` are oversampled, and `MISO` is driven from a register.

## Interface
Parameters:
- `CMD_PREFIX`, default `6'b100000`: required value of command byte bits [7:2] for the LED update to take effect.
- `SYNC_STAGES`, default `2`: synchronizer depth on `SS`, `SCLK` and `MOSI`. Legal values are 2 and 3.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `x_pos`  in  10  joystick X value, unsigned 0..1023.
- `y_pos`  in  10  joystick Y value, unsigned 0..1023.
- `buttons`  in  3  {btn2, btn1, trigger}.
- `SS`  in  1  slave select, active low.
- `SCLK`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `MOSI`  in  1  master data out.
- `MISO`  out  1  slave data out. Always driven, never tri-stated; 0 when not selected.
- `leds`  out  2  last valid LED command bits, {LD2, LD1}.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when all 5 bytes have completed.

## Operation
- **Input sampling:** `SS`, `SCLK` and `MOSI` each pass through a `SYNC_STAGES` synchronizer, followed by one delay register used for edge detection.
- **Frame start (sync'd `SS` falling edge):**
  - Snapshot `x_pos`, `y_pos` and `buttons` into a 40-bit frame register: byte0=`x[7:0]`, byte1=`{6'b0,x[9:8]}`, byte2=`y[7:0]`, byte3=`{6'b0,y[9:8]}`, byte4=`{5'b0,buttons}`.
  - Load byte0 into the tx shift register and drive `MISO` with its bit 7.
  - Clear the bit counter (3 bits) and set the byte index to 0.
  - State goes IDLE→SHIFT; `busy`=1.
- **Sync'd `SCLK` rising edge in SHIFT:** shift `MOSI` into the rx register, MSB first. Bit counter +1 (wraps 7→0).
- **Sync'd `SCLK` falling edge in SHIFT:**
  - Bit counter ≠0: shift tx left and drive the next bit.
  - Bit counter =0 (byte boundary): byte index +1. Load the next frame byte and drive its bit 7.
- **Byte 0 completion:** on the 8th rising edge of byte 0, if `rx[7:2]==CMD_PREFIX` then `leds<=rx[1:0]`; otherwise `leds` is unchanged. Bytes 1–4 received from the master are ignored.
- **Byte 4 completion (8th rising edge):** pulse `frame_done`; state goes SHIFT→DONE.
- **DONE:** `MISO`=0, all `SCLK` edges ignored, `busy` stays 1.
- **Sync'd `SS` rising edge, any state:** go to IDLE, `MISO`=0, `busy`=0, discard any partial rx byte. `leds` keeps whatever it last held. No `frame_done` if the abort happens before byte 4 completes.
- **Input changes mid-frame:** changes on `x_pos`/`y_pos`/`buttons` after the snapshot do not affect the frame in progress.
- **Simultaneous `SS` rise and `SCLK` edge in the same cycle:** `SS` wins. The edge is not processed.
- **`SCLK` edges while IDLE:** ignored.

## Timing
- **Reset values:** `MISO`=0, `leds`=2'b00, `busy`=0, `frame_done`=0, state=IDLE, frame/shift registers=0.
- **Reset is asynchronous:** asserting `rst` mid-frame forces all reset values immediately.
- **Edge-detect latency:** a pin edge is acted on `SYNC_STAGES`+1 clk cycles after it occurs.
- **`MISO` latency:** updates 1 cycle after the detected edge, i.e. `SYNC_STAGES`+2 cycles after the pin edge. With `SYNC_STAGES`=2 this is 4 cycles.
- **Clock ratio requirement:**
  - `SCLK` high and low phases ≥ `SYNC_STAGES`+3 clk cycles each.
  - `SS`-fall to first `SCLK` rise ≥ `SYNC_STAGES`+3 cycles.
  - PmodJSTK rates (≤1 MHz `SCLK`) satisfy this at 100 MHz.
- **Byte gaps:** inter-byte gaps of any length are tolerated; the bit counter just waits.
- **`leds` update:** 1 cycle after the 8th detected rising edge of byte 0.
- **`frame_done`:** high for exactly 1 cycle, 1 cycle after the 40th detected rising edge.

## Test plan
- **Full frame:** `x_pos`=10'h2A5, `y_pos`=10'h1F0, `buttons`=3'b101; master sends 8'h82 plus 4 dummy bytes at 1 MHz → `MISO` stream A5 02 F0 01 05, `leds`=2'b10, one `frame_done` pulse, `busy` low after `SS` rises.
- **Invalid command:** master sends 8'h43 as byte 0 → `leds` unchanged (keeps 2'b10), data bytes still correct.
- **Abort:** raise `SS` after 2.5 bytes → `busy`=0 and `MISO`=0 within `SYNC_STAGES`+2 cycles, no `frame_done`. The next frame restarts at byte0 with freshly sampled values.
- **Snapshot coherence:** change `x_pos` from 10'h000 to 10'h3FF during byte 1 → frame reports 00 00; the next frame reports FF 03.
- **Over-length frame:** master clocks 7 bytes → bytes 6–7 read 00, `frame_done` pulses only once.
- **Reset mid-frame:** assert `rst` during byte 3 → `leds`=00, `MISO`=0, `busy`=0 immediately. After `rst` is released, the next frame is fully correct.
